// File: rtl/bcd_serial_adder_if.sv
// ---------------------------------------------------------------------------
// bcd_serial_adder_if
//   Bundles the operand/handshake and result signals of bcd_serial_adder.
//   master : the block that issues operations (drives start/a/b/cin)
//   slave  : the adder itself (drives busy/done/sum/cout[/err])
// Signals
//   start  load request
//   a, b   BCD operands, 4*DIGITS bits, digit 0 in bits [3:0]
//   cin    decimal carry into digit 0
//   busy   adder is stepping through digits
//   done   one-cycle strobe, sum/cout valid
//   sum    BCD result
//   cout   decimal carry out of the top digit
//   err    invalid-digit flag (only when BCD_ERR_CHECK_EN is defined)
// ---------------------------------------------------------------------------
interface bcd_serial_adder_if #(
   parameter int DIGITS = 4
);
   logic                  start;
   logic [4*DIGITS-1:0]   a;
   logic [4*DIGITS-1:0]   b;
   logic                  cin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   sum;
   logic                  cout;
`ifdef BCD_ERR_CHECK_EN
   logic                  err;

   modport master (output start, a, b, cin, input busy, done, sum, cout, err);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout, err);
`else
   modport master (output start, a, b, cin, input busy, done, sum, cout);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/bcd_serial_adder.sv
// ---------------------------------------------------------------------------
// bcd_serial_adder
//   Digit-serial BCD adder. One BCD digit per clock goes through a 4-bit
//   binary add followed by +6 decimal correction; the decimal carry ripples
//   from digit to digit through a carry register.
//   Optional feature macro: BCD_ERR_CHECK_EN (adds the err flag on the bus).
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    bcd_serial_adder_if.slave: start/a/b/cin in, busy/done/sum/cout
//          (and err with BCD_ERR_CHECK_EN) out
// Timing
//   start sampled in IDLE or DONE; DIGITS ADD cycles follow; done is high for
//   one cycle in DONE. sum/cout hold until the next accepted start.
// ---------------------------------------------------------------------------
module bcd_serial_adder #(
   parameter int DIGITS = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   bcd_serial_adder_if.slave  bus
);

   localparam int W     = 4 * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [W-1:0]      a_sr, b_sr, sum_q;
   logic              carry_q, cout_q;
   logic [IDX_W-1:0]  idx_q;
   logic              accept;
   logic              busy_c, done_c;
   logic [4:0]        dig_res;
   logic              last_digit;

   // 4-bit add with carry-in, then +6 correction when the binary result
   // exceeds 9. Returns {decimal_carry, corrected_digit}.
   function automatic logic [4:0] bcd_digit_add(input logic [3:0] x,
                                                input logic [3:0] y,
                                                input logic       c);
      logic [4:0] t;
      t = {1'b0, x} + {1'b0, y} + {4'b0000, c};
      if (t > 5'd9)
         bcd_digit_add = {1'b1, t[3:0] + 4'd6};
      else
         bcd_digit_add = {1'b0, t[3:0]};
   endfunction

   assign dig_res    = bcd_digit_add(a_sr[3:0], b_sr[3:0], carry_q);
   assign last_digit = (idx_q == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      busy_c  = 1'b0;
      done_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = ADD;
            end
         end
         ADD: begin
            busy_c = 1'b1;
            if (last_digit) state_d = DONE;
         end
         DONE: begin
            done_c = 1'b1;
            if (bus.start) begin
               accept  = 1'b1;
               state_d = ADD;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr    <= '0;
         b_sr    <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else if (accept) begin
         a_sr    <= bus.a;
         b_sr    <= bus.b;
         carry_q <= bus.cin;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else if (state_q == ADD) begin
         a_sr    <= a_sr >> 4;
         b_sr    <= b_sr >> 4;
         carry_q <= dig_res[4];
         idx_q   <= idx_q + IDX_W'(1);
         // New digit enters at the MSD end; after DIGITS shifts digit 0 sits
         // in bits [3:0].
         sum_q   <= (sum_q >> 4) | (W'(dig_res[3:0]) << (W - 4));
         if (last_digit) cout_q <= dig_res[4];
      end
   end

`ifdef BCD_ERR_CHECK_EN
   logic err_q;

   // Checked on the live digit of each shift register, so every latched
   // digit is seen exactly once before DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_q <= 1'b0;
      else if (accept)
         err_q <= 1'b0;
      else if (state_q == ADD)
         err_q <= err_q | (a_sr[3:0] > 4'd9) | (b_sr[3:0] > 4'd9);
   end

   assign bus.err = err_q;
`endif

   assign bus.busy = busy_c;
   assign bus.done = done_c;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_bcd_serial_adder
//   Directed-vector bench for bcd_serial_adder with DIGITS=4. Expected sums
//   are hand-computed BCD values.
// ---------------------------------------------------------------------------
module tb_bcd_serial_adder;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;
`ifdef BCD_ERR_CHECK_EN
   logic last_err;
`endif

   bcd_serial_adder_if #(.DIGITS(4)) bus ();

   bcd_serial_adder #(.DIGITS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one op with a one-cycle start, then watch 12 cycles.
   task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic [15:0] exp_sum, input logic exp_cout,
                         input bit pulse_mid);
      int lat, busy_cnt, done_cnt;
      logic [15:0] s;
      logic co;
      lat = 0; busy_cnt = 0; done_cnt = 0; s = '0; co = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.a = av; bus.b = bv; bus.cin = ci;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            done_cnt++;
            if (lat == 0) begin
               lat = k; s = bus.sum; co = bus.cout;
`ifdef BCD_ERR_CHECK_EN
               last_err = bus.err;
`endif
            end
         end
         bus.start = pulse_mid && (k == 2);
      end
      check({tag, "_lat"},  32'(lat), 32'd5);
      check({tag, "_busy"}, 32'(busy_cnt), 32'd4);
      check({tag, "_ndone"}, 32'(done_cnt), 32'd1);
      check({tag, "_sum"},  {16'h0, s}, {16'h0, exp_sum});
      check({tag, "_cout"}, {31'h0, co}, {31'h0, exp_cout});
   endtask

   initial begin
      int dn;
      n_vec = 0; n_bad = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'h0, bus.busy}, 32'd0);
      check("rst_done", {31'h0, bus.done}, 32'd0);
      check("rst_sum",  {16'h0, bus.sum},  32'd0);
      check("rst_cout", {31'h0, bus.cout}, 32'd0);
      rst_n = 1'b1;

      run_op("t1", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
      run_op("t2", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("t3", 16'h0999, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b1);

      // back-to-back with start held high
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'h0005; bus.b = 16'h0005; bus.cin = 1'b0;
      dn = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (bus.done) begin
            dn++;
            if (dn == 1) begin
               check("b2b_t1",  32'(k), 32'd5);
               check("b2b_s1",  {16'h0, bus.sum}, 32'h0010);
            end else if (dn == 2) begin
               check("b2b_t2",  32'(k), 32'd10);
               check("b2b_s2",  {16'h0, bus.sum}, 32'h9999);
               check("b2b_c2",  {31'h0, bus.cout}, 32'd0);
            end
         end
         if (k == 1) begin bus.a = 16'h4999; bus.b = 16'h5000; end
         if (k == 10) bus.start = 1'b0;
      end
      check("b2b_ndone", 32'(dn), 32'd2);
      check("b2b_hold",  {16'h0, bus.sum}, 32'h9999);
      check("b2b_idle",  {31'h0, bus.busy}, 32'd0);

      // reset in the middle of an operation
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h1111;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mrst_busy", {31'h0, bus.busy}, 32'd0);
      check("mrst_done", {31'h0, bus.done}, 32'd0);
      check("mrst_sum",  {16'h0, bus.sum},  32'd0);
      check("mrst_cout", {31'h0, bus.cout}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus.done) dn++;
      end
      check("mrst_nodone", 32'(dn), 32'd0);
      run_op("t5", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

`ifdef BCD_ERR_CHECK_EN
      run_op("t6a", 16'h00A0, 16'h0001, 1'b0, 16'h0101, 1'b0, 1'b0);
      check("t6a_err", {31'h0, last_err}, 32'd1);
      run_op("t6b", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
      check("t6b_err", {31'h0, last_err}, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
